// File: rtl/modular_accumulator.sv
// -----------------------------------------------------------------------------
// modular_accumulator
//
// Sums a frame of residues modulo the prime Q. Beats arrive on a valid/ready
// input stream. The last beat of a frame is marked with in_last. The frame
// result (modular sum, count of added beats, error flag) is then held on a
// valid/ready output until it is consumed. A beat with in_data >= Q is still
// accepted, but it is not added. It sets the frame's error flag instead.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle
//   in_data    residue to add (WIDTH bits)
//   in_last    final beat of the frame
//   out_valid  frame result present
//   out_ready  consumer accepts the result
//   out_data   modular sum of the frame
//   out_count  number of beats added, saturating at 16'hFFFF
//   out_err    at least one beat of the frame was >= Q
// -----------------------------------------------------------------------------
module modular_accumulator #(
    parameter int unsigned     WIDTH = 30,
    parameter longint unsigned Q     = 64'd1068564481
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      out_count,
    output logic             out_err
);

    // Q widened by one bit, so that a sum of two residues can be compared
    // against it without overflow.
    localparam logic [WIDTH:0] Q_EXT = (WIDTH+1)'(Q);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [15:0]      cnt_q,   cnt_d;
    logic             err_q,   err_d;

    logic             accept;
    logic             beat_bad;
    logic [WIDTH-1:0] base_acc;
    logic [15:0]      base_cnt;
    logic             base_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first.
        // Without the defaults, paths that skip an assignment would infer latches.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        base_acc = acc_q;
        base_cnt = cnt_q;
        base_err = err_q;
        sum      = '0;
        sum_red  = '0;

        accept   = in_valid && (state_q != HOLD);
        beat_bad = ({1'b0, in_data} >= Q_EXT);

        // A beat accepted in IDLE opens a new frame. It is applied on top of
        // cleared state, not on top of whatever the last frame left behind.
        if (state_q == IDLE) begin
            base_acc = '0;
            base_cnt = '0;
            base_err = 1'b0;
        end

        if (accept) begin
            if (beat_bad) begin
                acc_d = base_acc;
                cnt_d = base_cnt;
                err_d = 1'b1;
            end else begin
                // Both operands are below Q. So s < 2Q, and one conditional
                // subtraction fully reduces the sum.
                sum     = {1'b0, base_acc} + {1'b0, in_data};
                sum_red = sum - Q_EXT;
                acc_d   = (sum >= Q_EXT) ? sum_red[WIDTH-1:0] : sum[WIDTH-1:0];
                cnt_d   = (base_cnt == 16'hFFFF) ? base_cnt : base_cnt + 16'd1;
                err_d   = base_err;
            end
            state_d = in_last ? HOLD : ACC;
        end

        if ((state_q == HOLD) && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All flops
        // then update together from the values present before the edge.
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The handshake outputs are decoded from the state register alone. rst
    // forces every output quiet during the reset cycle, including the cycle
    // before the first reset edge, when the state is not yet known.
    assign in_ready  = !rst && (state_q != HOLD);
    assign out_valid = !rst && (state_q == HOLD);
    assign out_data  = rst ? '0 : acc_q;
    assign out_count = rst ? '0 : cnt_q;
    assign out_err   = !rst && err_q;

endmodule

// File: tb/tb_modular_accumulator.sv
// -----------------------------------------------------------------------------
// tb_modular_accumulator
//
// Self-checking bench for modular_accumulator. Directed scenarios cover the
// worked examples, and a randomized run compares every frame result against a
// frame-level reference model: (sum of beats below Q) mod Q, the count of
// those beats, and whether any beat reached Q.
// -----------------------------------------------------------------------------
module tb_modular_accumulator;

    localparam int unsigned     W    = 30;
    localparam longint unsigned QL   = 64'd1068564481;
    localparam logic [W-1:0]    Q    = W'(QL);
    localparam logic [W-1:0]    QM1  = W'(QL - 64'd1);
    localparam logic [W-1:0]    MAXV = '1;

    typedef logic [W-1:0] beat_q_t[$];

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic         err;
        logic [15:0]  cnt;
        logic [W-1:0] data;
    } result_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [15:0]  out_count;
    logic         out_err;

    // {valid, err, count, data}, so a whole result is compared in one step.
    logic [W+17:0] res;
    assign res = {out_valid, out_err, out_count, out_data};

    int checks = 0;
    int errors = 0;

    modular_accumulator #(.WIDTH(W), .Q(QL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W+17:0] exp_res(input logic v, input logic e,
                                              input int c, input logic [W-1:0] d);
        return {v, e, 16'(c), d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame, one beat per cycle. The block must be in IDLE or ACC
    // when this is called. On return, the last beat has just been accepted.
    task automatic drive_frame(input beat_q_t beats);
        for (int i = 0; i < beats.size(); i++) begin
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == beats.size() - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, res} !== {1'b0, exp_res(0, 0, 0, '0)}) begin
            errors++;
            $display("FAIL reset_pre_edge: got ready=%0b res=%h, want ready=0 res=%h",
                     in_ready, res, exp_res(0, 0, 0, '0));
        end
        step();
        step();
        checks++;
        if ({in_ready, res} !== {1'b0, exp_res(0, 0, 0, '0)}) begin
            errors++;
            $display("FAIL reset_held: got ready=%0b res=%h, want ready=0 res=%h",
                     in_ready, res, exp_res(0, 0, 0, '0));
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got ready=%0b valid=%0b, want ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive_frame('{W'(10), W'(8)});
        checks++;
        if (res !== exp_res(1, 0, 2, W'(18))) begin
            errors++;
            $display("FAIL basic_sum: got %h, want %h", res, exp_res(1, 0, 2, W'(18)));
        end
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL basic_consume: got ready=%0b valid=%0b, want ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        drive_frame('{QM1, W'(1)});
        checks++;
        if (res !== exp_res(1, 0, 2, '0)) begin
            errors++;
            $display("FAIL wrap_to_zero: got %h, want %h", res, exp_res(1, 0, 2, '0));
        end
        step();
        drive_frame('{QM1, QM1});
        checks++;
        if (res !== exp_res(1, 0, 2, W'(1068564479))) begin
            errors++;
            $display("FAIL wrap_double: got %h, want %h", res, exp_res(1, 0, 2, W'(1068564479)));
        end
        step();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive_frame('{W'(0)});
        checks++;
        if (res !== exp_res(1, 0, 1, '0)) begin
            errors++;
            $display("FAIL hold_single_zero: got %h, want %h", res, exp_res(1, 0, 1, '0));
        end
        // Offer beats while the result is held. None of them may be taken.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = W'(123); in_last = 1'b1;
            step();
            checks++;
            if ({in_ready, res} !== {1'b0, exp_res(1, 0, 1, '0)}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got ready=%0b res=%h, want ready=0 res=%h",
                         i, in_ready, res, exp_res(1, 0, 1, '0));
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: got ready=%0b valid=%0b, want ready=1 valid=0",
                     in_ready, out_valid);
        end
        drive_frame('{W'(5)});
        checks++;
        if (res !== exp_res(1, 0, 1, W'(5))) begin
            errors++;
            $display("FAIL hold_next_frame: got %h, want %h", res, exp_res(1, 0, 1, W'(5)));
        end
        step();
    endtask

    task automatic test_invalid();
        out_ready = 1'b1;
        drive_frame('{W'(5), Q, W'(7)});
        checks++;
        if (res !== exp_res(1, 1, 2, W'(12))) begin
            errors++;
            $display("FAIL invalid_mixed: got %h, want %h", res, exp_res(1, 1, 2, W'(12)));
        end
        step();
        drive_frame('{MAXV});
        checks++;
        if (res !== exp_res(1, 1, 0, '0)) begin
            errors++;
            $display("FAIL invalid_only: got %h, want %h", res, exp_res(1, 1, 0, '0));
        end
        step();
        // The error flag must not leak into the following clean frame.
        drive_frame('{W'(4)});
        checks++;
        if (res !== exp_res(1, 0, 1, W'(4))) begin
            errors++;
            $display("FAIL invalid_cleared: got %h, want %h", res, exp_res(1, 0, 1, W'(4)));
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; in_last = 1'b0; in_data = W'(100);
        step();
        in_data = W'(200);
        step();
        // Reset must win over a simultaneous last beat.
        rst = 1'b1; in_valid = 1'b1; in_data = W'(999); in_last = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: got ready=%0b, want 0", in_ready);
        end
        step();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_idle: got ready=%0b valid=%0b, want ready=1 valid=0",
                     in_ready, out_valid);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_result: got valid=%0b, want 0", out_valid);
        end
        drive_frame('{W'(3), W'(4)});
        checks++;
        if (res !== exp_res(1, 0, 2, W'(7))) begin
            errors++;
            $display("FAIL reset_mid_next: got %h, want %h", res, exp_res(1, 0, 2, W'(7)));
        end
        step();
        // A reset while a result is held discards that result.
        out_ready = 1'b0;
        drive_frame('{W'(9)});
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hold_discard: got ready=%0b valid=%0b, want ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        beat_t   beats[$];
        result_t exp_q[$];
        int      cycles = 0;
        for (int f = 0; f < 20; f++) begin
            int              n = int'($urandom_range(300, 1));
            longint unsigned sum = 0;
            int              cnt = 0;
            logic            err = 1'b0;
            for (int b = 0; b < n; b++) begin
                logic [W-1:0] d;
                if ($urandom_range(9, 0) == 0) begin
                    d   = W'($urandom_range(32'(MAXV), 32'(Q)));
                    err = 1'b1;
                end else begin
                    d   = W'($urandom_range(32'(QM1), 0));
                    sum = (sum + longint'(d)) % QL;
                    cnt = (cnt == 65535) ? cnt : cnt + 1;
                end
                beats.push_back('{data: d, last: (b == n - 1)});
            end
            exp_q.push_back('{err: err, cnt: 16'(cnt), data: W'(sum)});
        end

        while ((beats.size() != 0 || exp_q.size() != 0) && cycles < 40000) begin
            checks++;
            if (in_ready !== !out_valid) begin
                errors++;
                $display("FAIL rand_handshake: got ready=%0b valid=%0b, want exactly one high",
                         in_ready, out_valid);
            end
            out_ready = out_valid ? ($urandom_range(3, 0) != 0) : 1'($urandom_range(1, 0));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_result: got %h, want no result", res);
                end else begin
                    result_t e = exp_q.pop_front();
                    if ({out_err, out_count, out_data} !== e) begin
                        errors++;
                        $display("FAIL rand_result: got err=%0b cnt=%0d data=%0d, want err=%0b cnt=%0d data=%0d",
                                 out_err, out_count, out_data, e.err, e.cnt, e.data);
                    end
                end
            end
            if (in_ready && beats.size() != 0 && $urandom_range(3, 0) != 0) begin
                beat_t bt = beats.pop_front();
                in_valid = 1'b1;
                in_data  = bt.data;
                in_last  = bt.last;
            end else if (!in_ready) begin
                // Garbage offered while the block is not ready. It must be ignored.
                in_valid = 1'($urandom_range(1, 0));
                in_data  = W'($urandom);
                in_last  = 1'($urandom_range(1, 0));
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                in_last  = 1'($urandom_range(1, 0));
            end
            step();
            cycles++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (cycles >= 40000) begin
            errors++;
            $display("FAIL rand_timeout: got %0d beats and %0d results pending, want 0 and 0",
                     beats.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modular_accumulator.md
MODULAR_ACCUMULATOR -- requirements
Module: modular_accumulator

Interface
REQ-001 Parameter Q, default 1068564481, is the prime modulus; all residues lie in [0, Q-1].
REQ-002 Parameter WIDTH, default 30, is the residue bit width; Q SHALL be less than 2^WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_data  input  WIDTH  residue to add.
REQ-008 in_last  input  1  marks the final beat of a frame.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  WIDTH  modular sum of the frame.
REQ-012 out_count  output  16  number of beats added in the frame, saturating.
REQ-013 out_err  output  1  at least one beat in the frame was rejected because in_data >= Q.

Function
REQ-014 A beat is accepted when in_valid and in_ready are both high on a rising edge; a result is consumed when out_valid and out_ready are both high.
REQ-015 FSM states: IDLE, ACC and HOLD.
REQ-016 IDLE: in_ready=1 and out_valid=0; an accepted beat starts a frame with acc=0, cnt=0, err=0 before that beat is applied.
REQ-017 IDLE transitions: accepted beat with in_last=0 -> ACC; accepted beat with in_last=1 -> HOLD.
REQ-018 ACC: in_ready=1 and out_valid=0; an accepted beat with in_last=1 -> HOLD; otherwise the FSM stays in ACC.
REQ-019 HOLD: in_ready=0 and out_valid=1; out_data, out_count and out_err stay stable until consumed; consumption -> IDLE.
REQ-020 Add rule: s = acc + in_data, computed in WIDTH+1 bits; acc_next = s - Q if s >= Q, else s; no other reduction is allowed.
REQ-021 A beat with in_data >= Q is accepted, including its in_last, but is not added and not counted; it sets err.
REQ-022 cnt increments per added beat and saturates at 16'hFFFF; acc still updates after saturation.
REQ-023 Latency: out_valid rises on the cycle after the in_last beat is accepted; out_data includes that beat.
REQ-024 A frame whose beats were all rejected yields out_data=0, out_count=0, out_err=1.
REQ-025 in_data and in_last are ignored whenever in_valid=0 or in_ready=0.
REQ-026 Consuming the result and accepting a new beat never happen in the same cycle; in HOLD in_ready=0, so the next frame starts one cycle after consumption at the earliest.
REQ-027 in_ready and out_valid depend only on the FSM state; there are no combinational paths from inputs to outputs.

Reset
REQ-028 When rst=1 at a rising edge, the FSM goes to IDLE and acc, cnt and err are cleared.
REQ-029 During reset: out_data=0, out_count=0, out_err=0, out_valid=0.
REQ-030 When rst=1, in_ready=0 in the same cycle; in the first cycle after rst falls, in_ready=1.
REQ-031 rst overrides every other input, including in_last and out_ready in the same cycle.
REQ-032 Reset in mid-frame or in HOLD discards the partial frame or pending result; no result is emitted for it.

Verification
REQ-033 Beats 10, 8 (last) with out_ready=1 -> one cycle after the last beat: out_data=18, out_count=2, out_err=0.
REQ-034 Wrap-around: beats 1068564480, 1 (last) -> out_data=0; beats 1068564480, 1068564480 (last) -> out_data=1068564479.
REQ-035 Single beat 0 with in_last=1 -> out_data=0, out_count=1; then hold out_ready=0 for 5 cycles -> out_valid stays 1, outputs stable, in_ready=0; raise out_ready -> IDLE next cycle.
REQ-036 Invalid input: beats 5, 1068564481, 7 (last) -> out_data=12, out_count=2, out_err=1; single beat 2^30-1 (last) -> out_data=0, out_count=0, out_err=1.
REQ-037 Reset mid-frame: beats 100, 200, then rst for 1 cycle, then beats 3, 4 (last) -> out_data=7, out_count=2, no result for the aborted frame.
REQ-038 Random frames of 1-300 beats with random in_valid/out_ready gaps, checked against a reference model ((sum of beats below Q) mod Q) -> all results match, beats are never accepted while in_ready=0.
